// File: rtl/rca32_acc_pkg.sv
// rtl/rca32_acc_pkg.sv - shared constants and FSM encoding for the rca32 accumulator
package rca32_acc_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca32_acc_if.sv
// rtl/rca32_acc_if.sv - control/stream bundle between operand source and accumulator
interface rca32_acc_if #(
  parameter int CNT_W = 8
);
  import rca32_acc_pkg::*;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] din;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             carry;

  // operand source side
  modport master (
    output start, len, in_valid, din,
    input  in_ready, busy, done, acc, carry
  );

  // accumulator side
  modport slave (
    input  start, len, in_valid, din,
    output in_ready, busy, done, acc, carry
  );

endinterface

// File: rtl/rca32_acc_rca32.sv
// rtl/rca32_acc_rca32.sv - purely combinational 32-bit ripple-carry adder
module rca32_acc_rca32
  import rca32_acc_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             ci,
  output logic [ACC_W-1:0] s,
  output logic             co
);

  logic cy;

  // ripple the carry bit by bit; cy is a running temporary, not a feedback net
  always_comb begin
    cy = ci;
    s  = '0;
    for (int i = 0; i < ACC_W; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/rca32_acc.sv
// rtl/rca32_acc.sv - streaming word accumulator built around one ripple-carry adder
module rca32_acc
  import rca32_acc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  rca32_acc_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] sum;
  logic             sum_co;
  logic             xfer;
  logic             start_ok;

  // the adder always sees the running sum and the current word
  rca32_acc_rca32 u_rca32 (
    .a  (acc_q),
    .b  (bus.din),
    .ci (1'b0),
    .s  (sum),
    .co (sum_co)
  );

  assign start_ok = (state == ST_IDLE) && bus.start;
  assign xfer     = (state == ST_ACC) && bus.in_valid;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: empty sums skip straight to DONE, last accepted word ends ACC
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (bus.in_valid && (cnt_q == CNT_W'(1))) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs depend on state only, so in_ready never loops back through in_valid
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      ST_ACC: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  // datapath: clear and latch len on accepted start, accumulate on each transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start_ok) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= bus.len;
    end else if (xfer) begin
      acc_q   <= sum;
      carry_q <= carry_q | sum_co;
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.acc   = acc_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_rca32_acc.sv
// tb/tb_rca32_acc.sv - directed table-driven bench for rca32_acc
module tb_rca32_acc;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  rca32_acc_if #(.CNT_W(8)) bus ();

  rca32_acc #(.CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              len;
    logic [3:0][31:0] w;
    logic [31:0]     fill;
    int              gap_at;
    int              gap_n;
    bit              spam;
    logic [31:0]     exp_acc;
    logic            exp_carry;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tv[8];
  vec_t tv_after_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, idx, xfers, gap_left, done_cyc, last_cyc, ready_seen;
    bit done_seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = v.len[7:0];
    bus.in_valid = 1'b1;
    bus.din      = 32'h1000_0000;
    cyc = 0; idx = 0; xfers = 0; gap_left = v.gap_n;
    done_cyc = 0; last_cyc = 0; ready_seen = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      bus.start = v.spam;
      bus.len   = 8'd1;
      if (bus.done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (bus.in_ready) ready_seen++;
      if (bus.in_ready && idx == v.gap_at && gap_left > 0) begin
        bus.in_valid = 1'b0;
        gap_left--;
      end else begin
        bus.in_valid = 1'b1;
        bus.din      = (idx < 4) ? v.w[idx[1:0]] : v.fill;
        if (bus.in_ready) begin
          idx++;
          xfers++;
          last_cyc = cyc;
        end
      end
    end
    chk({tag, " done_seen"}, 32'(done_seen), 32'd1);
    if (v.len > 0) chk({tag, " done_latency"}, done_cyc, last_cyc + 1);
    else begin
      chk({tag, " empty_done_cyc"}, done_cyc, 32'd1);
      chk({tag, " empty_ready_seen"}, ready_seen, 32'd0);
    end
    chk({tag, " xfers"}, xfers, v.len);
    chk({tag, " acc"}, bus.acc, v.exp_acc);
    chk({tag, " carry"}, 32'(bus.carry), 32'(v.exp_carry));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, " acc_hold"}, bus.acc, v.exp_acc);
    repeat (2) @(negedge clk);
    chk({tag, " carry_hold"}, 32'(bus.carry), 32'(v.exp_carry));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.din = '0;

    tv[0] = '{3,   {32'd0, 32'd3, 32'd2, 32'd1}, 32'd0, -1, 0, 1'b0, 32'd6, 1'b0};
    tv[1] = '{2,   {32'd0, 32'd0, 32'h2, 32'hFFFF_FFFF}, 32'd0, -1, 0, 1'b0, 32'h1, 1'b1};
    tv[2] = '{4,   {32'd40, 32'd30, 32'd20, 32'd10}, 32'd0, 2, 2, 1'b0, 32'd100, 1'b0};
    tv[3] = '{0,   {32'd9, 32'd9, 32'd9, 32'd9}, 32'd9, -1, 0, 1'b0, 32'd0, 1'b0};
    tv[4] = '{3,   {32'd0, 32'd5, 32'd5, 32'd5}, 32'd0, -1, 0, 1'b1, 32'd15, 1'b0};
    tv[5] = '{4,   {32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000}, 32'd0, 1, 1, 1'b0,
              32'h8000_0001, 1'b1};
    tv[6] = '{1,   {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF}, 32'd0, -1, 0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tv[7] = '{255, {32'd1, 32'd1, 32'd1, 32'd1}, 32'd1, -1, 0, 1'b0, 32'd255, 1'b0};
    tv_after_rst = '{1, {32'd0, 32'd0, 32'd0, 32'd7}, 32'd0, -1, 0, 1'b0, 32'd7, 1'b0};

    // reset state
    #1;
    chk("rst acc", bus.acc, 32'd0);
    chk("rst carry", 32'(bus.carry), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(tv[i], $sformatf("vec%0d", i));
    end

    // abandon a sum with reset after two of four words
    @(negedge clk);
    bus.start = 1'b1; bus.len = 8'd4; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.din = 32'h10;
    @(negedge clk);
    bus.din = 32'h20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid acc", bus.acc, 32'h30);
    chk("mid busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst acc", bus.acc, 32'd0);
    chk("mrst busy", 32'(bus.busy), 32'd0);
    chk("mrst in_ready", 32'(bus.in_ready), 32'd0);
    chk("mrst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    chk("mrst no_done", done_cnt, 32'd0);
    run_vec(tv_after_rst, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
